// File: rtl/ldl_fifo_pkg.sv
// Shared types and helpers for the ldl FIFO arbiters.
// rr_pick scans ptr+1, ptr+2, ... modulo n, so the requester at ptr has the lowest priority.
package ldl_fifo_pkg;

  typedef enum logic {IDLE, BUSY} arb_st_e;

  localparam int RR_MAX_N = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [3:0] ptr,
                                       input int n);
    rr_pick_t res;
    int cand;
    res = '0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      cand = (int'(ptr) + k) % n;
      if (k <= n && !res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational round-robin picker.
// It is shared by the write arbiter and by any later read-side arbiters.
module ldl_rr_pick
  import ldl_fifo_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  rr_pick_t pick;

  always_comb begin
    pick   = rr_pick(RR_MAX_N'(req), 4'(ptr), N);
    valid  = pick.valid;
    idx    = IW'(pick.idx);
    onehot = pick.valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/ldl_fifo_wr_arb.sv
// Packet-atomic round-robin arbiter sharing one FIFO write port between N requesters.
// A grant is held until an accepted last beat, or until MAXB beats have been accepted when MAXB is nonzero.
module ldl_fifo_wr_arb
  import ldl_fifo_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int MAXB = 0,
  parameter int CW   = 16,
  localparam int IW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    last,
  input  logic [N*DW-1:0] din,
  output logic [N-1:0]    gnt,
  input  logic            full,
  output logic            we,
  output logic [DW-1:0]   wd,
  output logic            busy,
  output logic [IW-1:0]   owner,
  output logic            trunc
);

  localparam bit            LIMITED   = (MAXB != 0);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXB - 1);

  arb_st_e       state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  ldl_rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign busy = (state == BUSY);
  assign we   = busy & req[owner] & ~full;
  assign gnt  = we ? (N'(1) << owner) : '0;
  assign wd   = din[owner*DW +: DW];

  // The release cycle always returns to IDLE, which creates the one-cycle gap between packets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= IW'(N - 1);
      beat   <= '0;
      trunc  <= 1'b0;
    end else begin
      trunc <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            beat  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (we) begin
            if (last[owner]) begin
              state  <= IDLE;
              rr_ptr <= owner;
              beat   <= '0;
            end else if (LIMITED && beat == LAST_BEAT) begin
              state  <= IDLE;
              rr_ptr <= owner;
              beat   <= '0;
              trunc  <= 1'b1;
            end else if (beat != '1) begin
              beat <= beat + CW'(1);
            end
          end
        end
      endcase
    end
  end

  a_gnt_onehot:    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_we:        assert property (@(posedge clk) disable iff (!rst_n) (gnt != '0) |-> we);
  a_we_not_full:   assert property (@(posedge clk) disable iff (!rst_n) we |-> !full);
  a_owner_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                                    (state == BUSY) |=> (state == IDLE || $stable(owner)));
  a_idle_no_gnt:   assert property (@(posedge clk) disable iff (!rst_n) (state == IDLE) |-> (gnt == '0));
  a_pick_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pick_onehot));

endmodule

// File: tb/tb_ldl_fifo_wr_arb.sv
// Scoreboard bench for ldl_fifo_wr_arb: per-requester beat sources, expected data queues,
// and a grant/trunc log that is checked against hand-derived cycle timings.
module tb_ldl_fifo_wr_arb;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int CW   = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, last, gnt;
  logic [N*DW-1:0] din;
  logic            full, we, busy, trunc;
  logic [DW-1:0]   wd;
  logic [1:0]      owner;

  beat_t         src_q[N][$];
  logic [DW-1:0] exp_q[N][$];
  int            gnt_cyc[$];
  int            gnt_idx[$];
  int            trunc_cyc[$];
  int            cyc = 0;
  int            t0;
  int            n_checks = 0;
  int            n_fails = 0;
  int            last_g[N];

  ldl_fifo_wr_arb #(.N(N), .DW(DW), .MAXB(MAXB), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .last  (last),
    .din   (din),
    .gnt   (gnt),
    .full  (full),
    .we    (we),
    .wd    (wd),
    .busy  (busy),
    .owner (owner),
    .trunc (trunc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input int beats, input logic [DW-1:0] base);
    beat_t b;
    for (int k = 0; k < beats; k++) begin
      b.last = (k == beats - 1);
      b.data = base + DW'(k);
      src_q[idx].push_back(b);
      exp_q[idx].push_back(b.data);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req[i]           = 1'b1;
        last[i]          = src_q[i][0].last;
        din[i*DW +: DW]  = src_q[i][0].data;
      end else begin
        req[i]           = 1'b0;
        last[i]          = 1'b0;
        din[i*DW +: DW]  = '0;
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
  task automatic runCycle();
    int g;
    @(negedge clk);
    cyc++;
    driveInputs();
    #1;
    checkOutput("we_matches_gnt", 32'(we), 32'(|gnt));
    if (trunc) trunc_cyc.push_back(cyc);
    if (gnt != '0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (gnt[i]) g = i;
      checkOutput("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      gnt_cyc.push_back(cyc);
      gnt_idx.push_back(g);
      if (src_q[g].size() == 0) begin
        checkOutput("gnt_without_req", 32'(g), 32'hFFFF_FFFF);
      end else begin
        checkOutput("wd", 32'(wd), 32'(exp_q[g].pop_front()));
        src_q[g].delete(0);
      end
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drainAll(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput("drain_timeout", 32'(pending()), 32'd0);
    runCycle();
    runCycle();
  endtask

  task automatic clearLogs();
    gnt_cyc.delete();
    gnt_idx.delete();
    trunc_cyc.delete();
  endtask

  function automatic int gIdx(input int k);
    return (k < gnt_idx.size()) ? gnt_idx[k] : -1;
  endfunction

  function automatic int gCyc(input int k);
    return (k < gnt_cyc.size()) ? gnt_cyc[k] - t0 : -1;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int e_off2[4];
    int e_off4[10];
    req   = '1;
    last  = '0;
    din   = '0;
    full  = 1'b0;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_trunc", 32'(trunc), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] two single-beat requesters");
    clearLogs();
    t0 = cyc;
    applyStimulus(0, 1, 8'hA0);
    applyStimulus(2, 1, 8'hC0);
    drainAll(20);
    checkOutput("t1_count", 32'(gnt_idx.size()), 32'd2);
    checkOutput("t1_idx0", 32'(gIdx(0)), 32'd0);
    checkOutput("t1_cyc0", 32'(gCyc(0)), 32'd2);
    checkOutput("t1_idx1", 32'(gIdx(1)), 32'd2);
    checkOutput("t1_cyc1", 32'(gCyc(1)), 32'd4);

    $display("[TB] packet atomicity with a competing requester");
    clearLogs();
    t0 = cyc;
    applyStimulus(1, 3, 8'h10);
    runCycle();
    applyStimulus(3, 1, 8'h30);
    drainAll(20);
    e_off2 = '{2, 3, 4, 6};
    checkOutput("t2_count", 32'(gnt_idx.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t2_idx", 32'(gIdx(k)), (k == 3) ? 32'd3 : 32'd1);
      checkOutput("t2_cyc", 32'(gCyc(k)), 32'(e_off2[k]));
    end

    $display("[TB] full backpressure mid-packet");
    clearLogs();
    t0 = cyc;
    applyStimulus(2, 4, 8'h20);
    runCycle();
    runCycle();
    full = 1'b1;
    repeat (5) begin
      runCycle();
      checkOutput("t3_we_full", 32'(we), 32'd0);
      checkOutput("t3_gnt_full", 32'(gnt), 32'd0);
      checkOutput("t3_owner_full", 32'(owner), 32'd2);
      checkOutput("t3_busy_full", 32'(busy), 32'd1);
    end
    full = 1'b0;
    drainAll(20);
    checkOutput("t3_count", 32'(gnt_idx.size()), 32'd4);
    checkOutput("t3_cyc0", 32'(gCyc(0)), 32'd2);
    checkOutput("t3_cyc1", 32'(gCyc(1)), 32'd8);
    checkOutput("t3_cyc3", 32'(gCyc(3)), 32'd10);

    $display("[TB] beat limit truncation");
    clearLogs();
    t0 = cyc;
    applyStimulus(0, 10, 8'h40);
    drainAll(40);
    e_off4 = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13};
    checkOutput("t4_count", 32'(gnt_idx.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t4_idx", 32'(gIdx(k)), 32'd0);
      checkOutput("t4_cyc", 32'(gCyc(k)), 32'(e_off4[k]));
    end
    checkOutput("t4_trunc_count", 32'(trunc_cyc.size()), 32'd2);
    if (trunc_cyc.size() == 2) begin
      checkOutput("t4_trunc0", 32'(trunc_cyc[0] - t0), 32'd6);
      checkOutput("t4_trunc1", 32'(trunc_cyc[1] - t0), 32'd11);
    end

    $display("[TB] all requesters with continuous single-beat traffic");
    clearLogs();
    t0 = cyc;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        applyStimulus(i, 1, 8'h80 + 8'(r * 16 + i));
    drainAll(40);
    for (int i = 0; i < N; i++) last_g[i] = t0;
    checkOutput("t5_count", 32'(gnt_idx.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      checkOutput("t5_idx", 32'(gIdx(k)), 32'((k + 1) % N));
      checkOutput("t5_cyc", 32'(gCyc(k)), 32'(2 + 2 * k));
      if (gIdx(k) >= 0 && gIdx(k) < N) begin
        checkOutput("t5_wait_bound", 32'(gnt_cyc[k] - last_g[gIdx(k)] <= 2 * N), 32'd1);
        last_g[gIdx(k)] = gnt_cyc[k];
      end
    end

    $display("[TB] asynchronous reset mid-packet");
    clearLogs();
    t0 = cyc;
    applyStimulus(1, 3, 8'h60);
    runCycle();
    runCycle();
    checkOutput("t6_first_idx", 32'(gIdx(0)), 32'd1);
    @(negedge clk);
    driveInputs();
    #1;
    checkOutput("t6_busy_pre", 32'(busy), 32'd1);
    checkOutput("t6_we_pre", 32'(we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_busy_rst", 32'(busy), 32'd0);
    checkOutput("t6_we_rst", 32'(we), 32'd0);
    checkOutput("t6_gnt_rst", 32'(gnt), 32'd0);
    checkOutput("t6_owner_rst", 32'(owner), 32'd0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    applyStimulus(1, 1, 8'h70);
    applyStimulus(3, 1, 8'h73);
    driveInputs();
    @(negedge clk);
    rst_n = 1'b1;
    clearLogs();
    t0 = cyc;
    drainAll(20);
    checkOutput("t6_count", 32'(gnt_idx.size()), 32'd2);
    checkOutput("t6_after_idx0", 32'(gIdx(0)), 32'd1);
    checkOutput("t6_after_idx1", 32'(gIdx(1)), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
